// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: an operand register followed by STAGES carry-chain slices.
// Defining PIPELINED_ADDER_SATURATE_EN adds the sat input and signed saturation of the result.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;

    logic             advance;
    logic             sat_in;
    logic             in_v_q;
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_b_q;
    logic             in_c_q;
    logic             in_s_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

`ifdef PIPELINED_ADDER_SATURATE_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // NOTE: the synchronous reset clears data as well as valids, so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_v_q <= 1'b0;
            in_a_q <= '0;
            in_b_q <= '0;
            in_c_q <= 1'b0;
            in_s_q <= 1'b0;
        end else if (advance) begin
            in_v_q <= in_valid;
            in_a_q <= a;
            in_b_q <= sub ? ~b : b;
            in_c_q <= sub | cin;
            in_s_q <= sat_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OW = WIDTH - k * SW;

        logic [OW-1:0]       op_a;
        logic [OW-1:0]       op_b;
        logic                c_in;
        logic                v_in;
        logic                s_in;
        logic [SW-1:0]       slice;
        logic                c_out;
        logic [(k+1)*SW-1:0] res_d;

        if (k == 0) begin : g_src
            assign op_a  = in_a_q;
            assign op_b  = in_b_q;
            assign c_in  = in_c_q;
            assign v_in  = in_v_q;
            assign s_in  = in_s_q;
            assign res_d = slice;
        end else begin : g_src
            assign op_a  = g_stage[k-1].g_mid.a_q;
            assign op_b  = g_stage[k-1].g_mid.b_q;
            assign c_in  = g_stage[k-1].g_mid.c_q;
            assign v_in  = g_stage[k-1].g_mid.v_q;
            assign s_in  = g_stage[k-1].g_mid.s_q;
            assign res_d = {slice, g_stage[k-1].g_mid.r_q};
        end

        assign {c_out, slice} = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (k < STAGES - 1) begin : g_mid
            // Upper operand bits ride along (skew); finished low slices ride along (deskew).
            logic                v_q;
            logic                c_q;
            logic                s_q;
            logic [(k+1)*SW-1:0] r_q;
            logic [OW-SW-1:0]    a_q;
            logic [OW-SW-1:0]    b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= 1'b0;
                    r_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    v_q <= v_in;
                    c_q <= c_out;
                    s_q <= s_in;
                    r_q <= res_d;
                    a_q <= op_a[OW-1:SW];
                    b_q <= op_b[OW-1:SW];
                end
            end
        end else begin : g_last
            logic             ovf_d;
            logic [WIDTH-1:0] sum_d;

            // Carry into the MSB is a^b^sum at that bit.
            assign ovf_d = op_a[SW-1] ^ op_b[SW-1] ^ slice[SW-1] ^ c_out;

            always_comb begin
                sum_d = res_d;
                if (s_in && ovf_d) begin
                    sum_d = op_a[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= v_in;
                    sum_q       <= sum_d;
                    cout_q      <= c_out;
                    ovf_q       <= ovf_d;
                    zero_q      <= (sum_d == '0);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
